// File: rtl/fft_bfly_r2.sv
`timescale 1ns/1ps
// Radix-2 DIT butterfly placed after the twiddle multiplier: delays operand A
// to meet W*B, forms A+WB / A-WB with halving or saturation, tracks frame beats.
module fft_bfly_r2 #(
    parameter int N        = 16,
    parameter int MULT_LAT = 2,
    parameter int PAIRS    = 512
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [N-1:0] in_ar,
    input  logic [N-1:0] in_ai,
    input  logic         scale,
    input  logic [N-1:0] wb_r,
    input  logic [N-1:0] wb_i,
    input  logic         ovf_clr,
    output logic         out_valid,
    output logic [N-1:0] x0_r,
    output logic [N-1:0] x0_i,
    output logic [N-1:0] x1_r,
    output logic [N-1:0] x1_i,
    output logic         out_last,
    output logic         ovf_sticky
);

    localparam int W  = 2 * N + 2;
    localparam int CW = (PAIRS > 2) ? $clog2(PAIRS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(PAIRS - 1);

    // Each stage holds {valid, scale, a_r, a_i}; no stall, so it shifts every cycle.
    logic [MULT_LAT-1:0][W-1:0] align_reg;
    logic [W-1:0]               in_word;
    logic [W-1:0]               tail;
    logic                       tail_valid;
    logic                       tail_scale;
    logic [N-1:0]               tail_ar;
    logic [N-1:0]               tail_ai;

    assign in_word    = {in_valid, scale, in_ar, in_ai};
    assign tail       = align_reg[MULT_LAT-1];
    assign tail_valid = tail[W-1];
    assign tail_scale = tail[W-2];
    assign tail_ar    = tail[2*N-1:N];
    assign tail_ai    = tail[N-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            align_reg <= '0;
        end else begin
            align_reg[0] <= in_word;
            for (int i = 1; i < MULT_LAT; i++) begin
                align_reg[i] <= align_reg[i-1];
            end
        end
    end

    // Component order: 0 = x0_r, 1 = x0_i, 2 = x1_r, 3 = x1_i.
    logic [3:0][N-1:0] res_next;
    logic [3:0]        clamp_next;

    for (genvar gi = 0; gi < 4; gi++) begin : g_comp
        localparam bit IMAG = (gi % 2) == 1;
        localparam bit SUB  = gi >= 2;

        logic signed [N:0] a_ext;
        logic signed [N:0] b_ext;
        logic signed [N:0] sum;
        logic              sat;

        assign a_ext = IMAG ? {tail_ai[N-1], tail_ai} : {tail_ar[N-1], tail_ar};
        assign b_ext = IMAG ? {wb_i[N-1], wb_i} : {wb_r[N-1], wb_r};
        assign sum   = SUB ? (a_ext - b_ext) : (a_ext + b_ext);
        // N+1-bit result fits in N bits only when its top two bits agree.
        assign sat   = sum[N] != sum[N-1];

        assign res_next[gi]   = tail_scale ? sum[N:1]
                              : sat ? {sum[N], {(N-1){~sum[N]}}}
                              : sum[N-1:0];
        assign clamp_next[gi] = !tail_scale && sat;
    end

    logic [CW-1:0] beat_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            ovf_sticky   <= 1'b0;
            x0_r         <= '0;
            x0_i         <= '0;
            x1_r         <= '0;
            x1_i         <= '0;
            beat_cnt_reg <= '0;
        end else begin
            out_valid  <= tail_valid;
            out_last   <= tail_valid && (beat_cnt_reg == LAST_BEAT);
            // A fresh clamp outranks a clear arriving on the same edge.
            ovf_sticky <= (tail_valid && |clamp_next) || (ovf_sticky && !ovf_clr);
            if (tail_valid) begin
                x0_r         <= res_next[0];
                x0_i         <= res_next[1];
                x1_r         <= res_next[2];
                x1_i         <= res_next[3];
                beat_cnt_reg <= (beat_cnt_reg == LAST_BEAT) ? '0 : beat_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_bfly_r2.sv
`timescale 1ns/1ps
// Scoreboard bench: three butterflies (MULT_LAT 2, 1, 5; PAIRS 4) share A-side
// stimulus, each fed W*B through its own delay; every cycle is checked.
module tb_fft_bfly_r2;

    localparam int N     = 16;
    localparam int PAIRS = 4;

    function automatic int ml_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 5;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          in_valid;
    logic          scale;
    logic [N-1:0]  in_ar, in_ai;
    logic [N-1:0]  wbr [3];
    logic [N-1:0]  wbi [3];
    logic          clr [3];
    logic          ov  [3];
    logic          ol  [3];
    logic          os  [3];
    logic [N-1:0]  x0r [3];
    logic [N-1:0]  x0i [3];
    logic [N-1:0]  x1r [3];
    logic [N-1:0]  x1i [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int ML = (gi == 0) ? 2 : (gi == 1) ? 1 : 5;
        fft_bfly_r2 #(.N(N), .MULT_LAT(ML), .PAIRS(PAIRS)) dut (
            .clk(clk), .reset(reset), .in_valid(in_valid),
            .in_ar(in_ar), .in_ai(in_ai), .scale(scale),
            .wb_r(wbr[gi]), .wb_i(wbi[gi]), .ovf_clr(clr[gi]),
            .out_valid(ov[gi]), .x0_r(x0r[gi]), .x0_i(x0i[gi]),
            .x1_r(x1r[gi]), .x1_i(x1i[gi]), .out_last(ol[gi]),
            .ovf_sticky(os[gi])
        );
    end

    typedef struct {
        int          due;
        logic [15:0] x0r, x0i, x1r, x1i;
        bit          last;
        bit          ovf;
    } exp_t;

    exp_t        q0[$], q1[$], q2[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [15:0] hist_r [16];
    logic [15:0] hist_i [16];
    int          issued [3];
    bit          exp_st [3];
    logic [63:0] held   [3];
    logic        clr_q  [3];
    int          clr_at [3];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) clr_q[k] <= clr[k];
    end

    // Reference arithmetic in plain integers; bit 16 flags a clamp.
    function automatic logic [16:0] bf(input logic [15:0] a, input logic [15:0] b,
                                       input bit sub, input bit sc);
        int v;
        v = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        if (sc) return {1'b0, 16'(v >>> 1)};
        if (v > 32767) return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(v)};
    endfunction

    function automatic int qs(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qf(input int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpop(input int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic chk(input string tag, input int k, input logic [95:0] got, input logic [95:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, got, want);
        end
    endtask

    task automatic push(input int k, input logic [15:0] ar, input logic [15:0] ai,
                        input logic [15:0] wr, input logic [15:0] wi, input bit sc);
        exp_t e;
        logic [16:0] r0, r1, r2, r3;
        r0 = bf(ar, wr, 1'b0, sc);
        r1 = bf(ai, wi, 1'b0, sc);
        r2 = bf(ar, wr, 1'b1, sc);
        r3 = bf(ai, wi, 1'b1, sc);
        e.due  = cyc + ml_of(k) + 1;
        e.x0r  = r0[15:0];
        e.x0i  = r1[15:0];
        e.x1r  = r2[15:0];
        e.x1i  = r3[15:0];
        e.ovf  = r0[16] | r1[16] | r2[16] | r3[16];
        e.last = (issued[k] % PAIRS) == PAIRS - 1;
        issued[k]++;
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic monitor(input int k);
        exp_t e;
        bit   has;
        while (qs(k) > 0) begin
            e = qf(k);
            if (e.due >= cyc) break;
            qpop(k);
        end
        has = 1'b0;
        if (qs(k) > 0) begin
            e   = qf(k);
            has = (e.due == cyc);
        end
        chk("out_valid", k, 96'(ov[k]), 96'(has));
        exp_st[k] = exp_st[k] & ~clr_q[k];
        if (has) begin
            qpop(k);
            chk("x0_x1", k, 96'({x0r[k], x0i[k], x1r[k], x1i[k]}), 96'({e.x0r, e.x0i, e.x1r, e.x1i}));
            chk("out_last", k, 96'(ol[k]), 96'(e.last));
            exp_st[k] = exp_st[k] | e.ovf;
            held[k]   = {e.x0r, e.x0i, e.x1r, e.x1i};
        end else begin
            chk("out_last_idle", k, 96'(ol[k]), 96'(0));
            chk("hold", k, 96'({x0r[k], x0i[k], x1r[k], x1i[k]}), 96'(held[k]));
        end
        chk("ovf_sticky", k, 96'(os[k]), 96'(exp_st[k]));
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            for (int k = 0; k < 3; k++) monitor(k);
        end
    end

    // One call per clock cycle; also plays the multiplier by replaying W*B MULT_LAT cycles late.
    task automatic drive(input bit rst, input bit v, input bit sc,
                         input logic [15:0] ar, input logic [15:0] ai,
                         input logic [15:0] wr, input logic [15:0] wi);
        @(posedge clk);
        #1;
        reset    = ~rst;
        in_valid = v && !rst;
        scale    = in_valid ? sc : 1'($urandom);
        in_ar    = in_valid ? ar : 16'($urandom);
        in_ai    = in_valid ? ai : 16'($urandom);
        hist_r[cyc % 16] = in_valid ? wr : 16'($urandom);
        hist_i[cyc % 16] = in_valid ? wi : 16'($urandom);
        for (int k = 0; k < 3; k++) begin
            wbr[k] = hist_r[(cyc + 16 - ml_of(k)) % 16];
            wbi[k] = hist_i[(cyc + 16 - ml_of(k)) % 16];
            clr[k] = (cyc == clr_at[k]);
        end
        if (rst) begin
            q0.delete(); q1.delete(); q2.delete();
            for (int k = 0; k < 3; k++) begin
                issued[k] = 0;
                exp_st[k] = 1'b0;
                held[k]   = '0;
                clr_at[k] = -100;
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                chk("reset_outs", k, 96'({ov[k], ol[k], os[k], x0r[k], x0i[k], x1r[k], x1i[k]}), 96'(0));
            end
        end else if (in_valid) begin
            for (int k = 0; k < 3; k++) push(k, ar, ai, wr, wi, sc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic issue(input bit sc, input logic [15:0] ar, input logic [15:0] ai,
                         input logic [15:0] wr, input logic [15:0] wi);
        drive(1'b0, 1'b1, sc, ar, ai, wr, wi);
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        scale    = 1'b0;
        in_ar    = '0;
        in_ai    = '0;
        for (int k = 0; k < 3; k++) begin
            wbr[k] = '0; wbi[k] = '0; clr[k] = 1'b0;
            clr_at[k] = -100; issued[k] = 0; exp_st[k] = 1'b0; held[k] = '0;
        end
        for (int i = 0; i < 16; i++) begin
            hist_r[i] = 16'($urandom);
            hist_i[i] = 16'($urandom);
        end

        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

        // Plain add/subtract, no clamp.
        issue(1'b0, 16'h2000, 16'h1000, 16'h1000, 16'hF000);
        idle(7);
        // Halving at both extremes.
        issue(1'b1, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000);
        idle(7);
        // Saturation high and low.
        issue(1'b0, 16'h7000, 16'h9000, 16'h2000, 16'h2000);
        idle(7);
        // Clear lands on the same edge as a new clamp: sticky must stay set.
        for (int k = 0; k < 3; k++) clr_at[k] = cyc + 1 + ml_of(k);
        issue(1'b0, 16'h7000, 16'h9000, 16'h2000, 16'h2000);
        idle(7);
        // Clear with nothing clamping.
        for (int k = 0; k < 3; k++) clr_at[k] = cyc + 1;
        idle(4);

        // Random pairs with 0..3-cycle gaps.
        for (int i = 0; i < 6; i++) begin
            issue(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            idle(int'($urandom_range(0, 3)));
        end
        idle(8);

        // Eight back-to-back pairs with distinct A for alignment.
        for (int i = 0; i < 8; i++) begin
            issue(1'($urandom), 16'(16'h0101 * (i + 1)), 16'(16'hF00F - 16'h0111 * i),
                  16'($urandom), 16'($urandom));
        end
        idle(8);

        // Reset mid-frame with two pairs in flight, then a fresh frame of four.
        issue(1'b0, 16'h1234, 16'h4321, 16'h0100, 16'h0200);
        issue(1'b0, 16'h2345, 16'h5432, 16'h0300, 16'h0400);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 16'(16'h0400 * (i + 1)), 16'(16'h0100 * i), 16'h0123, 16'hFEDC);
        end
        idle(10);

        for (int k = 0; k < 3; k++) chk("drained", k, 96'(qs(k)), 96'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
